uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Configurable UART receiver: oversampled serial RX line -> parallel word, with optional parity,
//  1/2 stop bits, 3-sample majority vote, false-start rejection, error flags and break detection.
//  Sits between the baud-rate tick generator and the MIDI/command FIFO; drop-in successor to the
//  fixed 8N1 receiver: same clk/s_tick scheme, adds a registered done pulse and error reporting.
// PARAMETERS
//  DBIT       8   data bits per frame, legal 5..9, LSB received first
//  OS         16  s_tick pulses per bit period, legal even values >= 8
//  PARITY     0   0 = none, 1 = even, 2 = odd
//  STOP_BITS  1   stop bits checked, 1 or 2
// PORTS
//  clk           in   1     system clock
//  reset         in   1     asynchronous, active-high
//  rx            in   1     raw serial line, idle high, asynchronous to clk
//  s_tick        in   1     1-clk oversample enable, OS per bit period
//  rx_done_tick  out  1     1-clk pulse: frame complete; dout and flags valid on the same cycle
//  dout          out  DBIT  last received data word, held until next rx_done_tick
//  parity_err    out  1     parity mismatch on last frame (always 0 when PARITY=0), held
//  frame_err     out  1     a stop bit sampled 0 on last frame, held
//  break_det     out  1     1-clk pulse coincident with rx_done_tick: break condition
// BEHAVIOUR
//  Reset: state=IDLE, counters=0, dout=0, all flags/pulses 0, rx synchroniser flops = 1.
//  rx passes through a 2-flop synchroniser -> rx_s. All decisions use rx_s only.
//  s counter: width $clog2(OS). n counter: width $clog2(DBIT+1).
//   All counters advance only on s_tick; no state change without s_tick except IDLE exit.
//  States:
//   IDLE : rx_s==0 -> START, s=0 (no s_tick needed).
//   START: on s_tick, s++. At s==OS/2-1: rx_s==1 -> IDLE (glitch, no output);
//          else -> DATA, s=0, n=0. This aligns s==OS-1 with the middle of each following bit.
//   DATA : samples v0,v1,v2 taken at s==OS-3, OS-2, OS-1. bit = majority(v0,v1,v2).
//          At s==OS-1: shift b={bit,b[DBIT-1:1]}, s=0, n++. After bit DBIT-1:
//          -> PAR if PARITY!=0, else -> STOP.
//   PAR  : same 3-sample vote. pbit: even -> perr = ^b ^ pbit; odd -> perr = ~(^b ^ pbit). -> STOP.
//   STOP : same vote per stop bit. fe |= (bit==0). After STOP_BITS bits, at the last s==OS-1:
//          next clk: rx_done_tick=1, dout<=b, parity_err<=perr, frame_err<=fe,
//          break_det = fe & (b==0) & (pbit==0 or PARITY==0).
//          Then -> IDLE if no break, else -> BRK.
//   BRK  : wait for rx_s==1 (no s_tick needed) -> IDLE. Prevents retrigger on a held-low line.
//  Latency: rx_done_tick asserts exactly 1 clk after the s_tick that samples the final stop bit,
//   i.e. mid last stop bit, so the next start edge is never missed.
//  frame_err frames still deliver dout. Flags are updated only on rx_done_tick.
//  Glitch: a low pulse on rx_s shorter than OS/2 ticks -> no rx_done_tick, back to IDLE.
//  A single-tick disturbance inside any bit is voted out; it causes no error.
//  Reset mid-frame: immediate return to IDLE; partial frame discarded; no pulse emitted.
//  rx low at reset release: after the synchroniser a normal frame is attempted,
//   which normally ends as break -> BRK.
//  s_tick and rx_done_tick never overlap in a way that drops a tick; the counters keep running.
// TESTING
//  8N1, OS=16: send 0x55 then 0xA3 back-to-back -> two rx_done_tick, dout=0x55 then 0xA3,
//   flags 0.
//  PARITY=1: 0x07 with parity bit 1 -> parity_err=0; same with parity bit 0 -> parity_err=1.
//   dout=0x07 in both cases.
//  Stop bit driven 0 on 0x3C -> rx_done_tick, dout=0x3C, frame_err=1, break_det=0.
//   Next good frame clears frame_err.
//  rx low for 5 s_ticks (OS=16) -> no rx_done_tick, state IDLE. 1-tick low inside a data bit
//   -> correct dout.
//  rx low for 3 frame times -> one rx_done_tick with dout=0, frame_err=1, break_det=1.
//   No further pulses until rx high again.
//  reset asserted mid DATA of 0xF0 -> outputs 0, no pulse. Next 0x81 after release
//   -> dout=0x81. Repeat with DBIT=9, STOP_BITS=2.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// Serial-receive bundle for uart_rx_cfg: the oversampled line and tick go in,
// the received word, error flags and the completion pulse come out.
interface uart_rx_cfg_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic            s_tick;
    logic            rx_done_tick;
    logic [DBIT-1:0] dout;
    logic            parity_err;
    logic            frame_err;
    logic            break_det;

    modport master (
        output rx, s_tick,
        input  rx_done_tick, dout, parity_err, frame_err, break_det
    );

    modport slave (
        input  rx, s_tick,
        output rx_done_tick, dout, parity_err, frame_err, break_det
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable oversampled UART receiver: majority-voted bits, optional parity,
// 1/2 stop bits, false-start rejection, frame/parity error and break reporting.
module uart_rx_cfg #(
    parameter int DBIT      = 8,
    parameter int OS        = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_cfg_if.slave  bus
);
    localparam int SW = $clog2(OS);
    localparam int NW = $clog2(DBIT + 1);
    localparam logic [SW-1:0] S_ONE  = SW'(1);
    localparam logic [SW-1:0] S_MID  = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] S_V0   = SW'(OS - 3);
    localparam logic [SW-1:0] S_V1   = SW'(OS - 2);
    localparam logic [SW-1:0] S_LAST = SW'(OS - 1);
    localparam logic [NW-1:0] N_ONE  = NW'(1);
    localparam logic [NW-1:0] N_DLST = NW'(DBIT - 1);
    localparam logic [NW-1:0] N_SLST = NW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic par_err(input logic [DBIT-1:0] d, input logic p);
        logic e;
        e = (^d) ^ p;
        return (PARITY == 2) ? ~e : e;
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      sync_q;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [1:0]      v_q, v_d;
    logic            pbit_q, pbit_d, perr_q, perr_d, fe_q, fe_d;
    logic            done_q, done_d, brk_q, brk_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            perr_o_q, perr_o_d, fe_o_q, fe_o_d;
    logic            rx_s, vbit_s, fe_fin_s, brk_s;

    assign rx_s     = sync_q[1];
    assign vbit_s   = maj3(v_q[0], v_q[1], rx_s);
    assign fe_fin_s = fe_q | ~vbit_s;
    assign brk_s    = fe_fin_s & (b_q == '0) & ((PARITY == 0) || !pbit_q);

    // Two-flop synchroniser on the asynchronous line, idling high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], bus.rx};
    end

    // All receiver state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            s_q      <= '0;
            n_q      <= '0;
            b_q      <= '0;
            v_q      <= 2'b00;
            pbit_q   <= 1'b0;
            perr_q   <= 1'b0;
            fe_q     <= 1'b0;
            done_q   <= 1'b0;
            brk_q    <= 1'b0;
            dout_q   <= '0;
            perr_o_q <= 1'b0;
            fe_o_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            n_q      <= n_d;
            b_q      <= b_d;
            v_q      <= v_d;
            pbit_q   <= pbit_d;
            perr_q   <= perr_d;
            fe_q     <= fe_d;
            done_q   <= done_d;
            brk_q    <= brk_d;
            dout_q   <= dout_d;
            perr_o_q <= perr_o_d;
            fe_o_q   <= fe_o_d;
        end
    end

    // Next-state logic; the first two votes of every bit are captured at OS-3 and OS-2.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        b_d      = b_q;
        v_d      = v_q;
        pbit_d   = pbit_q;
        perr_d   = perr_q;
        fe_d     = fe_q;
        done_d   = 1'b0;
        brk_d    = 1'b0;
        dout_d   = dout_q;
        perr_o_d = perr_o_q;
        fe_o_d   = fe_o_q;

        if (bus.s_tick && (s_q == S_V0)) begin
            v_d[0] = rx_s;
        end else if (bus.s_tick && (s_q == S_V1)) begin
            v_d[1] = rx_s;
        end else begin
            v_d = v_q;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bus.s_tick && (s_q == S_MID)) begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        s_d     = '0;
                        n_d     = '0;
                        fe_d    = 1'b0;
                        perr_d  = 1'b0;
                        pbit_d  = 1'b0;
                    end
                end else if (bus.s_tick) begin
                    s_d = s_q + S_ONE;
                end else begin
                    s_d = s_q;
                end
            end
            DATA: begin
                if (bus.s_tick && (s_q == S_LAST)) begin
                    b_d = {vbit_s, b_q[DBIT-1:1]};
                    s_d = '0;
                    if (n_q == N_DLST) begin
                        n_d     = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        n_d = n_q + N_ONE;
                    end
                end else if (bus.s_tick) begin
                    s_d = s_q + S_ONE;
                end else begin
                    s_d = s_q;
                end
            end
            PAR: begin
                if (bus.s_tick && (s_q == S_LAST)) begin
                    pbit_d  = vbit_s;
                    perr_d  = par_err(b_q, vbit_s);
                    s_d     = '0;
                    state_d = STOP;
                end else if (bus.s_tick) begin
                    s_d = s_q + S_ONE;
                end else begin
                    s_d = s_q;
                end
            end
            STOP: begin
                if (bus.s_tick && (s_q == S_LAST)) begin
                    s_d  = '0;
                    fe_d = fe_fin_s;
                    if (n_q == N_SLST) begin
                        n_d      = '0;
                        done_d   = 1'b1;
                        dout_d   = b_q;
                        perr_o_d = perr_q;
                        fe_o_d   = fe_fin_s;
                        brk_d    = brk_s;
                        state_d  = brk_s ? BRK : IDLE;
                    end else begin
                        n_d = n_q + N_ONE;
                    end
                end else if (bus.s_tick) begin
                    s_d = s_q + S_ONE;
                end else begin
                    s_d = s_q;
                end
            end
            BRK: begin
                // Held-low line must return high before a new start can be seen.
                if (rx_s) state_d = IDLE;
                else      state_d = BRK;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rx_done_tick = done_q;
    assign bus.dout         = dout_q;
    assign bus.parity_err   = perr_o_q;
    assign bus.frame_err    = fe_o_q;
    assign bus.break_det    = brk_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three configurations (8N1, 8E1, 9N2) share clock,
// tick and reset; each completed frame is queued by a monitor and compared in the tests.
module tb_uart_rx_cfg;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       st = 1'b0;
    logic [2:0] rxv = 3'b111;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [13:0] exp_q[$];
    logic [13:0] obs_q[$];

    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DBIT(8)) if0 ();
    uart_rx_cfg_if #(.DBIT(8)) if1 ();
    uart_rx_cfg_if #(.DBIT(9)) if2 ();
    assign if0.rx = rxv[0];
    assign if1.rx = rxv[1];
    assign if2.rx = rxv[2];
    assign if0.s_tick = st;
    assign if1.s_tick = st;
    assign if2.s_tick = st;

    uart_rx_cfg #(.DBIT(8), .OS(16), .PARITY(0), .STOP_BITS(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    uart_rx_cfg #(.DBIT(8), .OS(16), .PARITY(1), .STOP_BITS(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    uart_rx_cfg #(.DBIT(9), .OS(16), .PARITY(0), .STOP_BITS(2)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    // record = {src[1:0], dout[8:0], parity_err, frame_err, break_det}
    always @(negedge clk) begin
        if (if0.rx_done_tick) obs_q.push_back({2'd0, 1'b0, if0.dout, if0.parity_err, if0.frame_err, if0.break_det});
        if (if1.rx_done_tick) obs_q.push_back({2'd1, 1'b0, if1.dout, if1.parity_err, if1.frame_err, if1.break_det});
        if (if2.rx_done_tick) obs_q.push_back({2'd2, if2.dout, if2.parity_err, if2.frame_err, if2.break_det});
    end

    task automatic tick();
        @(negedge clk) st = 1'b1;
        @(negedge clk) st = 1'b0;
    endtask

    task automatic send_bit(input int w, input logic v, input int nt);
        rxv[w] = v;
        repeat (nt) tick();
    endtask

    task automatic send_frame(input int w, input logic [8:0] d, input int nb, input bit use_p,
                              input logic pb, input int ns, input bit stop_low);
        send_bit(w, 1'b0, 16);
        for (int i = 0; i < nb; i++) send_bit(w, d[i], 16);
        if (use_p) send_bit(w, pb, 16);
        for (int k = 0; k < ns; k++) begin
            if (stop_low) begin
                send_bit(w, 1'b0, 10);
                send_bit(w, 1'b1, 6);
            end else begin
                send_bit(w, 1'b1, 16);
            end
        end
    endtask

    task automatic test_reset();
        logic [13:0] o;
        reset = 1'b1;
        rxv = 3'b111;
        repeat (3) @(negedge clk);
        #1;
        o = {2'd0, 1'b0, if0.dout, if0.parity_err, if0.frame_err, if0.break_det};
        n_checks++;
        if (o !== 14'd0 || if0.rx_done_tick !== 1'b0) $display("FAIL reset_dut0 got %h done=%b want 0", o, if0.rx_done_tick);
        else n_pass++;
        o = {2'd0, if2.dout, if2.parity_err, if2.frame_err, if2.break_det};
        n_checks++;
        if (o !== 14'd0 || if2.rx_done_tick !== 1'b0) $display("FAIL reset_dut2 got %h done=%b want 0", o, if2.rx_done_tick);
        else n_pass++;
        @(negedge clk) reset = 1'b0;
        repeat (4) tick();
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL reset_no_pulse got %0d pulses want 0", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [13:0] e, o;
        exp_q.push_back({2'd0, 9'h055, 3'b000});
        send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b0);
        exp_q.push_back({2'd0, 9'h0A3, 3'b000});
        send_frame(0, 9'h0A3, 8, 1'b0, 1'b0, 1, 1'b0);
        send_bit(0, 1'b1, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                $display("FAIL b2b_missing got no pulse want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL b2b_frame got %h want %h", o, e);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL b2b_extra got %0d extra pulses want 0", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_parity();
        logic [13:0] e, o;
        exp_q.push_back({2'd1, 9'h007, 3'b000});
        send_frame(1, 9'h007, 8, 1'b1, 1'b1, 1, 1'b0);
        send_bit(1, 1'b1, 8);
        exp_q.push_back({2'd1, 9'h007, 3'b100});
        send_frame(1, 9'h007, 8, 1'b1, 1'b0, 1, 1'b0);
        exp_q.push_back({2'd1, 9'h0C3, 3'b000});
        send_frame(1, 9'h0C3, 8, 1'b1, 1'b0, 1, 1'b0);
        send_bit(1, 1'b1, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                $display("FAIL parity_missing got no pulse want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL parity_frame got %h want %h", o, e);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL parity_extra got %0d extra pulses want 0", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_frame_err();
        logic [13:0] e, o;
        exp_q.push_back({2'd0, 9'h03C, 3'b010});
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
        send_bit(0, 1'b1, 16);
        exp_q.push_back({2'd0, 9'h05A, 3'b000});
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b0);
        send_bit(0, 1'b1, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                $display("FAIL ferr_missing got no pulse want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL ferr_frame got %h want %h", o, e);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL ferr_extra got %0d extra pulses want 0", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_glitch();
        logic [13:0] e, o;
        logic [7:0]  d;
        send_bit(0, 1'b0, 5);
        send_bit(0, 1'b1, 40);
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL glitch_no_pulse got %0d pulses want 0", obs_q.size());
        else n_pass++;
        // One-tick disturbances on sampled positions of bits 1, 2 and 5 must be voted out.
        d = 8'hC6;
        exp_q.push_back({2'd0, 1'b0, d, 3'b000});
        send_bit(0, 1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == 1 || i == 2 || i == 5) begin
                send_bit(0, d[i], 7);
                send_bit(0, ~d[i], 1);
                send_bit(0, d[i], 8);
            end else begin
                send_bit(0, d[i], 16);
            end
        end
        send_bit(0, 1'b1, 36);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                $display("FAIL vote_missing got no pulse want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL vote_frame got %h want %h", o, e);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL vote_extra got %0d extra pulses want 0", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_break();
        logic [13:0] e, o;
        exp_q.push_back({2'd0, 9'h000, 3'b011});
        send_bit(0, 1'b0, 480);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                $display("FAIL break_missing got no pulse want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL break_frame got %h want %h", o, e);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL break_retrigger got %0d extra pulses want 0", obs_q.size());
        else n_pass++;
        send_bit(0, 1'b1, 20);
        exp_q.push_back({2'd0, 9'h012, 3'b000});
        send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1, 1'b0);
        send_bit(0, 1'b1, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                $display("FAIL break_recover_missing got no pulse want %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL break_recover got %h want %h", o, e);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL break_recover_extra got %0d extra pulses want 0", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid(input int w, input int nb, input int ns, input logic [8:0] warm);
        logic [13:0] e, o;
        logic [8:0]  part;
        exp_q.push_back({2'(w), warm, 3'b000});
        send_frame(w, warm, nb, 1'b0, 1'b0, ns, 1'b0);
        send_bit(w, 1'b1, 8);
        part = 9'h0F0;
        send_bit(w, 1'b0, 16);
        for (int i = 0; i < 6; i++) send_bit(w, part[i], 16);
        @(negedge clk);
        reset = 1'b1;
        rxv = 3'b111;
        #1;
        if (w == 2) o = {2'd0, if2.dout, if2.parity_err, if2.frame_err, if2.break_det};
        else        o = {2'd0, 1'b0, if0.dout, if0.parity_err, if0.frame_err, if0.break_det};
        n_checks++;
        if (o !== 14'd0) $display("FAIL rstmid_outputs dut%0d got %h want 0", w, o);
        else n_pass++;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        send_bit(w, 1'b1, 20);
        exp_q.push_back({2'(w), 9'h081, 3'b000});
        send_frame(w, 9'h081, nb, 1'b0, 1'b0, ns, 1'b0);
        send_bit(w, 1'b1, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                $display("FAIL rstmid_missing dut%0d got no pulse want %h", w, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL rstmid_frame dut%0d got %h want %h", w, o, e);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL rstmid_extra dut%0d got %0d extra pulses want 0", w, obs_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_parity();
        test_frame_err();
        test_glitch();
        test_break();
        test_reset_mid(0, 8, 1, 9'h0F3);
        test_reset_mid(2, 9, 2, 9'h1F3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
